mem_ctrl: RTL

//  Memory controller between the MAR/MBR datapath and the 256x8 main store. Accepts the

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/mem_ctrl_array.sv | 45 ++++
 rtl/mem_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg
//   Shared definitions for the memory controller slice: controller FSM state
//   encoding, default address/data widths and the wait-state counter width.
//   Imported by mem_ctrl and mem_ctrl_array.
package cpu_pkg;

    // Controller states. An access always runs IDLE -> WAIT -> DONE -> IDLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int DEF_AW = 8;
    localparam int DEF_DW = 8;

    // Wait-state counter width; it holds WAIT values 0..15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_ctrl_array.sv
// mem_ctrl_array
//   Single-port synchronous storage array for the memory controller: one write
//   port and a registered read port sharing one address. The storage itself is
//   never reset; only the read register clears on reset.
// Ports
//   clk      in   1   rising-edge clock
//   reset_n  in   1   synchronous active-low reset (read register only)
//   we       in   1   write enable, mem[addr] <= wdata on this edge
//   re       in   1   read enable, rdata <= mem[addr] on this edge
//   addr     in   AW  shared read/write address
//   wdata    in   W   write word
//   rdata    out  W   registered read word, holds until the next read
module mem_ctrl_array
    import cpu_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int W  = DEF_DW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [2**AW];

    // Storage has no reset so the program image survives a CPU reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl
//   Memory controller between the MAR/MBR datapath and the main store. A level
//   request (req, rnw) is captured in IDLE, WAIT wait states are inserted, the
//   access commits and mfc is raised; mfc stays high until req drops, which
//   returns the controller to IDLE on the same edge (4-phase handshake).
//   A boot-load port writes host bytes while the CPU is idle.
//
//   Load handshake: a byte is accepted on an edge where the controller is in
//   IDLE, req is low, load_valid is high and load_ready is low. The write lands
//   on that edge and load_ready is high for exactly the following cycle; the
//   host treats (load_valid & load_ready) as "byte taken". A CPU request in the
//   same IDLE cycle wins and the load simply waits.
//
//   Optional feature macro: MEM_PARITY_EN. When defined, each word carries an
//   even-parity bit and a read whose word has bad parity sets the sticky
//   parity_err output. When undefined the array is DW wide and parity_err is
//   not present.
// Ports
//   clk, reset_n            clock, synchronous active-low reset
//   req, rnw, addr, wdata   CPU access request (level), direction, address, write data
//   rdata, mfc, busy        last read data, memory function complete, not-IDLE
//   load_valid/addr/data    boot-load byte from the host
//   load_ready              one-cycle pulse after a boot-load byte is written
//   parity_err              sticky read parity error (MEM_PARITY_EN only)
module mem_ctrl
    import cpu_pkg::*;
#(
    parameter int AW   = DEF_AW,
    parameter int DW   = DEF_DW,
    parameter int WAIT = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req,
    input  logic          rnw,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          mfc,
    output logic          busy,
    input  logic          load_valid,
    input  logic [AW-1:0] load_addr,
    input  logic [DW-1:0] load_data,
    output logic          load_ready
`ifdef MEM_PARITY_EN
   ,output logic          parity_err
`endif
);

`ifdef MEM_PARITY_EN
    localparam int MW = DW + 1;
`else
    localparam int MW = DW;
`endif

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [AW-1:0]    addr_q;
    logic [DW-1:0]    wdata_q;
    logic             rnw_q;

    logic             commit;
    logic             load_accept;
    logic [AW-1:0]    arr_addr;
    logic [DW-1:0]    arr_data;
    logic [MW-1:0]    arr_wword;
    logic [MW-1:0]    arr_rword;
    logic             arr_we;
    logic             arr_re;

    // The access commits on the edge where the wait counter has reached zero.
    // Capture always enters WAIT, so WAIT=0 gives the minimum one-cycle access.
    assign commit      = (state == S_WAIT) && (cnt == '0);
    assign load_accept = (state == S_IDLE) && !req && load_valid && !load_ready;

    // Load writes only happen in IDLE and CPU commits only in WAIT, so one port suffices.
    assign arr_addr = (state == S_IDLE) ? load_addr : addr_q;
    assign arr_data = (state == S_IDLE) ? load_data : wdata_q;

    // Reset gates the enables so an access aborted by reset never touches the array.
    assign arr_we = reset_n && ((commit && !rnw_q) || load_accept);
    assign arr_re = reset_n && commit && rnw_q;

`ifdef MEM_PARITY_EN
    assign arr_wword = {^arr_data, arr_data};
`else
    assign arr_wword = arr_data;
`endif

    mem_ctrl_array #(
        .AW (AW),
        .W  (MW)
    ) u_array (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (arr_we),
        .re      (arr_re),
        .addr    (arr_addr),
        .wdata   (arr_wword),
        .rdata   (arr_rword)
    );

    assign rdata = arr_rword[DW-1:0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rnw_q      <= 1'b0;
            mfc        <= 1'b0;
            busy       <= 1'b0;
            load_ready <= 1'b0;
        end else begin
            load_ready <= load_accept;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        rnw_q   <= rnw;
                        cnt     <= CNT_W'(WAIT);
                        state   <= S_WAIT;
                        busy    <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        mfc   <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    if (!req) begin
                        mfc   <= 1'b0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    mfc   <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MEM_PARITY_EN
    // The read word is registered at commit, so its parity is checked one cycle later.
    logic chk_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            chk_q      <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            chk_q <= arr_re;
            if (chk_q && (^arr_rword)) begin
                parity_err <= 1'b1;
            end
        end
    end
`endif

endmodule
